// File: rtl/height_update_scheduler_if.sv
// Signal bundle between the height update scheduler and its loader/display peers.
// The pause input exists only when HEIGHT_SCHED_PAUSE_EN is defined.
interface height_update_scheduler_if;
  logic       frame_tick;
  logic [9:0] sw;
  logic       loaded;
`ifdef HEIGHT_SCHED_PAUSE_EN
  logic       pause;
`endif
  logic       update;
  logic [9:0] sel;
  logic       busy;
  logic       swap;
  logic       timeout_err;
  logic [7:0] skipped;

`ifdef HEIGHT_SCHED_PAUSE_EN
  modport master (output frame_tick, sw, loaded, pause,
                  input  update, sel, busy, swap, timeout_err, skipped);
  modport slave  (input  frame_tick, sw, loaded, pause,
                  output update, sel, busy, swap, timeout_err, skipped);
`else
  modport master (output frame_tick, sw, loaded,
                  input  update, sel, busy, swap, timeout_err, skipped);
  modport slave  (input  frame_tick, sw, loaded,
                  output update, sel, busy, swap, timeout_err, skipped);
`endif
endinterface

// File: rtl/height_update_scheduler.sv
// Schedules height-buffer reloads every FRAMES_PER_UPDATE frames and hands the result to display.
// Optional feature: define HEIGHT_SCHED_PAUSE_EN to add a synchronized pause input that blocks slots.
module height_update_scheduler #(
  parameter int FRAMES_PER_UPDATE = 2,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  height_update_scheduler_if.slave  bus
);
  // One state bit per output so update/swap/busy each come straight off a flop.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ISSUE = 3'b101,
    WAIT  = 3'b100,
    SWAP  = 3'b110
  } state_t;

  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_UPDATE - 1);
  localparam logic [9:0] WAIT_LAST  = 10'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [9:0] sw_m, sw_s;
  logic [7:0] frame_cnt;
  logic [9:0] wait_cnt;
  logic       pending;
  logic [9:0] sel_q;
  logic [7:0] skipped_q;
  logic       timeout_q;
  logic       slot, slot_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= bus.sw;
      sw_s <= sw_m;
    end
  end

`ifdef HEIGHT_SCHED_PAUSE_EN
  logic pause_m, pause_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pause_m <= 1'b0;
      pause_s <= 1'b0;
    end else begin
      pause_m <= bus.pause;
      pause_s <= pause_m;
    end
  end

  // Frames keep counting while paused; only the resulting slot is dropped.
  assign slot_ok = slot & ~pause_s;
`else
  assign slot_ok = slot;
`endif

  assign slot = bus.frame_tick && (frame_cnt == FRAME_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            frame_cnt <= '0;
    else if (bus.frame_tick) frame_cnt <= slot ? 8'd0 : frame_cnt + 8'd1;
  end

  // IDLE always consumes pending, so pending only builds up while a load is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= 1'b0;
      skipped_q <= '0;
    end else begin
      if (slot_ok && pending && skipped_q != 8'hFF) skipped_q <= skipped_q + 8'd1;
      if (state == IDLE)  pending <= 1'b0;
      else if (slot_ok)   pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending || slot_ok) begin
            state <= ISSUE;
            sel_q <= sw_s;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (bus.loaded) begin
            state <= SWAP;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        SWAP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.update      = state[0];
  assign bus.swap        = state[1];
  assign bus.busy        = state[2];
  assign bus.sel         = sel_q;
  assign bus.skipped     = skipped_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_height_update_scheduler.sv
// Randomized bench for height_update_scheduler against an event-level reference model.
module tb_height_update_scheduler;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  height_update_scheduler_if bus0();
  height_update_scheduler_if bus1();

  height_update_scheduler #(.FRAMES_PER_UPDATE(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  height_update_scheduler #(.FRAMES_PER_UPDATE(1), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  logic       which = 1'b0;
  logic       tick  = 1'b0;
  logic       ld    = 1'b0;
  logic       pz    = 1'b0;
  logic [9:0] swv   = '0;

  assign bus0.frame_tick = tick & ~which;
  assign bus1.frame_tick = tick & which;
  assign bus0.loaded     = ld & ~which;
  assign bus1.loaded     = ld & which;
  assign bus0.sw         = swv;
  assign bus1.sw         = swv;
`ifdef HEIGHT_SCHED_PAUSE_EN
  assign bus0.pause      = pz;
  assign bus1.pause      = pz;
`endif

  logic       o_update, o_swap, o_busy, o_timeout;
  logic [9:0] o_sel;
  logic [7:0] o_skipped;
  assign o_update  = which ? bus1.update      : bus0.update;
  assign o_swap    = which ? bus1.swap        : bus0.swap;
  assign o_busy    = which ? bus1.busy        : bus0.busy;
  assign o_timeout = which ? bus1.timeout_err : bus0.timeout_err;
  assign o_sel     = which ? bus1.sel         : bus0.sel;
  assign o_skipped = which ? bus1.skipped     : bus0.skipped;

  int         cyc, tick_per, tick_ph, ld_delay, sw_at, pz_on, pz_off;
  logic [9:0] sw_next;
  int         ticks_q[$];
  bit         tick_blk_q[$];
  logic [9:0] sw_hist[$];
  bit         pz_hist[$];
  int         ld_q[$];
  int         upd_q[$], swap_q[$];
  logic [9:0] sel_q[$];
  int         busy_n, to_cyc, overlap, sel_bad;
  bit         prev_upd;
  logic [9:0] cur_sel;
  int         exp_upd[$], exp_swap[$];
  int         exp_skip, exp_to, exp_busy;
  int         n_tests = 0;
  int         n_fail  = 0;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_obs();
    upd_q.delete(); swap_q.delete(); sel_q.delete();
    busy_n = 0; to_cyc = -1; overlap = 0; sel_bad = 0; prev_upd = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick = 1'b0; ld = 1'b0; pz = 1'b0;
    repeat (2) @(posedge clk);
    ticks_q.delete(); tick_blk_q.delete(); sw_hist.delete(); pz_hist.delete(); ld_q.delete();
    clear_obs();
    sw_at = -1; pz_on = -1; pz_off = -1; cyc = -1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One loop iteration per clock: drive after the rising edge, observe on the falling edge.
  task automatic run(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == sw_at) swv = sw_next;
      sw_hist.push_back(swv);
      if (cyc == pz_on)  pz = 1'b1;
      if (cyc == pz_off) pz = 1'b0;
      pz_hist.push_back(pz);
      tick = (tick_per > 0) && (cyc >= tick_ph) && (((cyc - tick_ph) % tick_per) == 0);
      if (tick) begin
        ticks_q.push_back(cyc);
        tick_blk_q.push_back(cyc >= 2 ? pz_hist[cyc-2] : 1'b0);
      end
      ld = 1'b0;
      if (ld_q.size() > 0 && ld_q[0] == cyc) begin
        ld = 1'b1;
        void'(ld_q.pop_front());
      end
      @(negedge clk);
      if (o_update) begin
        upd_q.push_back(cyc);
        sel_q.push_back(o_sel);
        cur_sel = o_sel;
        if (ld_delay > 0) ld_q.push_back(cyc + ld_delay);
        if (prev_upd) overlap++;
      end
      prev_upd = o_update;
      if (o_swap) swap_q.push_back(cyc);
      if (o_busy) busy_n++;
      if (o_busy && !o_update && o_sel !== cur_sel) sel_bad++;
      if (o_timeout && to_cyc < 0) to_cyc = cyc;
    end
  endtask

  // Reference model: one load occupies a fixed span of cycles starting at its update.
  task automatic model_issue(input int u, input int last, input int len);
    if (u > last) return;
    exp_upd.push_back(u);
    if (ld_delay > 0 && ld_delay <= TO) begin
      if (u + ld_delay + 1 <= last) exp_swap.push_back(u + ld_delay + 1);
    end else if (exp_to < 0 && u + TO + 1 <= last) begin
      exp_to = u + TO + 1;
    end
    exp_busy += (u + len - 1 <= last) ? len : last - u + 1;
  endtask

  task automatic model(input int fpu);
    int u, e, len, nt, c, last;
    bit pend;
    last = cyc;
    exp_upd.delete(); exp_swap.delete();
    exp_skip = 0; exp_to = -1; exp_busy = 0;
    len  = (ld_delay > 0 && ld_delay <= TO) ? ld_delay + 2 : TO + 1;
    e    = -1000;
    pend = 0;
    nt   = 0;
    for (int i = 0; i < ticks_q.size(); i++) begin
      c = ticks_q[i];
      nt++;
      if ((nt % fpu) != 0 || tick_blk_q[i] || c >= last) continue;
      if (pend && c > e) begin
        u = e + 1;
        model_issue(u, last, len);
        e = u + len;
        pend = 0;
      end
      if (c < e || (c == e && pend)) begin
        if (pend) begin
          if (exp_skip < 255) exp_skip++;
        end else begin
          pend = 1;
        end
      end else begin
        u = c + 1;
        model_issue(u, last, len);
        e = u + len;
      end
    end
    if (pend) model_issue(e + 1, last, len);
  endtask

  task automatic test_reset();
    which = 1'b0; reset_n = 1'b0; tick = 1'b0; ld = 1'b0; swv = 10'h3FF;
    repeat (2) @(negedge clk);
    n_tests++; if (o_update !== 1'b0) begin n_fail++; $display("FAIL reset update: got %b expected 0", o_update); end
    n_tests++; if (o_swap !== 1'b0) begin n_fail++; $display("FAIL reset swap: got %b expected 0", o_swap); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", o_busy); end
    n_tests++; if (o_sel !== 10'd0) begin n_fail++; $display("FAIL reset sel: got %0d expected 0", o_sel); end
    n_tests++; if (o_skipped !== 8'd0) begin n_fail++; $display("FAIL reset skipped: got %0d expected 0", o_skipped); end
    n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset timeout_err: got %b expected 0", o_timeout); end
  endtask

  task automatic test_basic();
    int n;
    for (int it = 0; it < 4; it++) begin
      which = 1'b0;
      if (it == 0) begin
        swv = 10'd4; tick_per = 100; tick_ph = 10; ld_delay = 18;
      end else begin
        swv = 10'($urandom); tick_per = $urandom_range(40, 120);
        tick_ph = $urandom_range(5, 9); ld_delay = $urandom_range(1, TO);
      end
      do_reset();
      run(1000);
      model(2);
      n_tests++;
      if (upd_q.size() != exp_upd.size()) begin
        n_fail++; $display("FAIL basic[%0d] update count: got %0d expected %0d", it, upd_q.size(), exp_upd.size());
      end
      n = (upd_q.size() < exp_upd.size()) ? upd_q.size() : exp_upd.size();
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (upd_q[i] != exp_upd[i]) begin
          n_fail++; $display("FAIL basic[%0d] update cycle %0d: got %0d expected %0d", it, i, upd_q[i], exp_upd[i]);
        end
        n_tests++;
        if (sel_q[i] !== sw_hist[exp_upd[i]-3]) begin
          n_fail++; $display("FAIL basic[%0d] sel %0d: got %0d expected %0d", it, i, sel_q[i], sw_hist[exp_upd[i]-3]);
        end
      end
      n_tests++;
      if (swap_q.size() != exp_swap.size()) begin
        n_fail++; $display("FAIL basic[%0d] swap count: got %0d expected %0d", it, swap_q.size(), exp_swap.size());
      end
      n = (swap_q.size() < exp_swap.size()) ? swap_q.size() : exp_swap.size();
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (swap_q[i] != exp_swap[i]) begin
          n_fail++; $display("FAIL basic[%0d] swap cycle %0d: got %0d expected %0d", it, i, swap_q[i], exp_swap[i]);
        end
      end
      n_tests++;
      if (busy_n != exp_busy) begin
        n_fail++; $display("FAIL basic[%0d] busy cycles: got %0d expected %0d", it, busy_n, exp_busy);
      end
      if (it == 0) begin
        n_tests++;
        if (busy_n != 20 * upd_q.size() || upd_q.size() == 0) begin
          n_fail++; $display("FAIL basic busy per load: got %0d total for %0d loads expected 20 each", busy_n, upd_q.size());
        end
      end
      n_tests++;
      if (to_cyc != -1 || o_skipped !== 8'd0 || overlap != 0 || sel_bad != 0) begin
        n_fail++; $display("FAIL basic[%0d] side effects: timeout_cyc=%0d skipped=%0d overlap=%0d sel_bad=%0d expected -1/0/0/0",
                           it, to_cyc, o_skipped, overlap, sel_bad);
      end
    end
  endtask

  task automatic test_boundary_delay();
    int n;
    int dly[2];
    dly[0] = 1; dly[1] = TO;
    for (int it = 0; it < 2; it++) begin
      which = 1'b0; swv = 10'($urandom); tick_per = 100; tick_ph = 10; ld_delay = dly[it];
      do_reset();
      run(700);
      model(2);
      n_tests++;
      if (swap_q.size() != exp_swap.size() || swap_q.size() == 0) begin
        n_fail++; $display("FAIL delay%0d swap count: got %0d expected %0d", dly[it], swap_q.size(), exp_swap.size());
      end
      n = (swap_q.size() < exp_swap.size()) ? swap_q.size() : exp_swap.size();
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (swap_q[i] != exp_swap[i]) begin
          n_fail++; $display("FAIL delay%0d swap cycle %0d: got %0d expected %0d", dly[it], i, swap_q[i], exp_swap[i]);
        end
      end
      n_tests++;
      if (to_cyc != -1) begin
        n_fail++; $display("FAIL delay%0d timeout_err: got set at %0d expected never", dly[it], to_cyc);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    which = 1'b0; swv = 10'($urandom); tick_per = 100; tick_ph = 10; ld_delay = 0;
    do_reset();
    run(600);
    model(2);
    n_tests++;
    if (to_cyc != exp_to || upd_q.size() == 0 || to_cyc != upd_q[0] + TO + 1) begin
      n_fail++; $display("FAIL timeout cycle: got %0d expected %0d", to_cyc, exp_to);
    end
    n_tests++;
    if (swap_q.size() != 0) begin
      n_fail++; $display("FAIL timeout swap count: got %0d expected 0", swap_q.size());
    end
    n_tests++;
    if (upd_q.size() != exp_upd.size() || upd_q.size() < 2) begin
      n_fail++; $display("FAIL timeout update count: got %0d expected %0d", upd_q.size(), exp_upd.size());
    end
    n = (upd_q.size() < exp_upd.size()) ? upd_q.size() : exp_upd.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (upd_q[i] != exp_upd[i]) begin
        n_fail++; $display("FAIL timeout update cycle %0d: got %0d expected %0d", i, upd_q[i], exp_upd[i]);
      end
    end
    n_tests++;
    if (busy_n != exp_busy || o_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout busy/sticky: busy=%0d flag=%b expected %0d/1", busy_n, o_timeout, exp_busy);
    end
  endtask

  task automatic test_skip();
    int n;
    for (int it = 0; it < 3; it++) begin
      which = 1'b1; swv = 10'($urandom); tick_ph = 5;
      if (it == 1) begin
        tick_per = $urandom_range(6, 14); ld_delay = $urandom_range(20, 60);
      end else begin
        tick_per = 10; ld_delay = 40;
      end
      do_reset();
      run(it == 2 ? 4000 : 400);
      model(1);
      n_tests++;
      if (o_skipped !== 8'(exp_skip)) begin
        n_fail++; $display("FAIL skip[%0d] skipped: got %0d expected %0d", it, o_skipped, exp_skip);
      end
      if (it == 2) begin
        n_tests++;
        if (o_skipped !== 8'd255) begin
          n_fail++; $display("FAIL skip saturation: got %0d expected 255", o_skipped);
        end
      end
      n_tests++;
      if (upd_q.size() != exp_upd.size() || overlap != 0) begin
        n_fail++; $display("FAIL skip[%0d] updates: got %0d (overlap %0d) expected %0d (overlap 0)",
                           it, upd_q.size(), overlap, exp_upd.size());
      end
      n = (upd_q.size() < exp_upd.size()) ? upd_q.size() : exp_upd.size();
      for (int i = 0; i < n && i < 12; i++) begin
        n_tests++;
        if (upd_q[i] != exp_upd[i]) begin
          n_fail++; $display("FAIL skip[%0d] update cycle %0d: got %0d expected %0d", it, i, upd_q[i], exp_upd[i]);
        end
      end
    end
    which = 1'b0;
  endtask

  task automatic test_sel_hold();
    which = 1'b0; swv = 10'd4; tick_per = 100; tick_ph = 10; ld_delay = 30;
    do_reset();
    sw_at = 121; sw_next = 10'd8;
    run(400);
    n_tests++;
    if (sel_q.size() < 2) begin
      n_fail++; $display("FAIL selhold update count: got %0d expected 2", sel_q.size());
    end else begin
      n_tests++;
      if (sel_q[0] !== 10'd4) begin n_fail++; $display("FAIL selhold first sel: got %0d expected 4", sel_q[0]); end
      n_tests++;
      if (sel_q[1] !== 10'd8) begin n_fail++; $display("FAIL selhold second sel: got %0d expected 8", sel_q[1]); end
    end
    n_tests++;
    if (sel_bad != 0) begin n_fail++; $display("FAIL selhold sel moved while busy: got %0d cycles expected 0", sel_bad); end
  endtask

  task automatic test_reset_wait();
    int guard;
    which = 1'b0; swv = 10'd4; tick_per = 100; tick_ph = 10; ld_delay = 0;
    do_reset();
    guard = 0;
    while (upd_q.size() == 0 && guard < 400) begin
      run(1);
      guard++;
    end
    n_tests++;
    if (upd_q.size() == 0) begin
      n_fail++; $display("FAIL rstwait update: got none within %0d cycles expected one", guard);
    end
    run(5);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({o_update, o_swap, o_busy, o_timeout} !== 4'b0000 || o_sel !== 10'd0 || o_skipped !== 8'd0) begin
      n_fail++; $display("FAIL rstwait async clear: got upd=%b swap=%b busy=%b to=%b sel=%0d skip=%0d expected all 0",
                         o_update, o_swap, o_busy, o_timeout, o_sel, o_skipped);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick_per = 0;
    clear_obs();
    ld_q.delete();
    ld_q.push_back(cyc + 3);
    run(100);
    n_tests++;
    if (swap_q.size() != 0 || upd_q.size() != 0 || busy_n != 0) begin
      n_fail++; $display("FAIL rstwait late loaded: got swaps=%0d updates=%0d busy=%0d expected 0/0/0",
                         swap_q.size(), upd_q.size(), busy_n);
    end
    n_tests++;
    if (to_cyc != -1) begin
      n_fail++; $display("FAIL rstwait timeout_err: got set at %0d expected never", to_cyc);
    end
  endtask

`ifdef HEIGHT_SCHED_PAUSE_EN
  task automatic test_pause();
    int n, in_win;
    which = 1'b0; swv = 10'($urandom); tick_per = 50; tick_ph = 5; ld_delay = 10;
    do_reset();
    pz_on = 100; pz_off = 360;
    run(600);
    model(2);
    in_win = 0;
    foreach (upd_q[i]) if (upd_q[i] > 102 && upd_q[i] <= 362) in_win++;
    n_tests++;
    if (in_win != 0) begin n_fail++; $display("FAIL pause updates while paused: got %0d expected 0", in_win); end
    n_tests++;
    if (o_skipped !== 8'd0) begin n_fail++; $display("FAIL pause skipped: got %0d expected 0", o_skipped); end
    n_tests++;
    if (upd_q.size() != exp_upd.size()) begin
      n_fail++; $display("FAIL pause update count: got %0d expected %0d", upd_q.size(), exp_upd.size());
    end
    n = (upd_q.size() < exp_upd.size()) ? upd_q.size() : exp_upd.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (upd_q[i] != exp_upd[i]) begin
        n_fail++; $display("FAIL pause update cycle %0d: got %0d expected %0d", i, upd_q[i], exp_upd[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundary_delay();
    test_timeout();
    test_skip();
    test_sel_hold();
    test_reset_wait();
`ifdef HEIGHT_SCHED_PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
